// File: rtl/usb_fs_tx_buffer_if.sv
// Transmitter-side pull interface of usb_fs_tx_buffer: packet start/PID, byte pull, end-of-packet.
// Handshake: tx_data is valid whenever tx_data_avail=1; a tx_data_get pulse pops it, a get without avail is ignored.
interface usb_fs_tx_buffer_if;
  logic       pkt_start;
  logic [3:0] pid;
  logic       tx_data_avail;
  logic       tx_data_get;
  logic [7:0] tx_data;
  logic       pkt_end;

  modport master (
    output pkt_start, pid, tx_data_avail, tx_data,
    input  tx_data_get, pkt_end
  );

  modport slave (
    input  pkt_start, pid, tx_data_avail, tx_data,
    output tx_data_get, pkt_end
  );
endinterface

// File: rtl/usb_fs_tx_buffer.sv
// Packet transmit buffer feeding the USB FS transmitter: byte FIFO, packet commit FSM, pull interface.
// Define USB_TX_RETRY_EN to keep sent bytes until ack and allow replay on retry.
module usb_fs_tx_buffer #(
  parameter int ADDR_W  = 7,
  parameter int MAX_PKT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              wr_full,
  output logic [ADDR_W:0]   level,
  input  logic              send_req,
  input  logic [3:0]        send_pid,
  output logic              busy,
  output logic              done,
  input  logic              ack,
  input  logic              retry,
  usb_fs_tx_buffer_if.master tx,
  output logic [2:0]        state_dbg
);

  localparam int              PTR_W    = ADDR_W + 1;
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] MAX_LEN  = PTR_W'(MAX_PKT);
  localparam logic [ADDR_W:0] FULL_LVL = PTR_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_SEND     = 3'd2,
    S_DONE     = 3'd3,
    S_WAIT_ACK = 3'd4
  } state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr, base_ptr, end_ptr;
  logic [ADDR_W:0] pkt_len;
  logic            wr_accept;
  logic            pkt_start_q, done_q;
  logic [3:0]      pid_q;

  // Occupancy counts from base_ptr so bytes awaiting ack still hold their slots.
  assign level     = wr_ptr - base_ptr;
  assign wr_full   = (level == FULL_LVL);
  assign wr_accept = wr_en && !wr_full;
  assign pkt_len   = (level < MAX_LEN) ? level : MAX_LEN;

  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign state_dbg = state;

  assign tx.pkt_start     = pkt_start_q;
  assign tx.pid           = pid_q;
  assign tx.tx_data_avail = (state == S_SEND) && (rd_ptr != end_ptr);
  assign tx.tx_data       = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

`ifndef USB_TX_RETRY_EN
  logic unused_ctrl;
  assign unused_ctrl = ack ^ retry;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      base_ptr    <= '0;
      end_ptr     <= '0;
      pid_q       <= 4'h0;
      pkt_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pkt_start_q <= 1'b0;
      done_q      <= 1'b0;
      if (wr_accept) wr_ptr <= wr_ptr + PTR_W'(1);

      case (state)
        S_IDLE: begin
          if (send_req) begin
            pid_q       <= send_pid;
            rd_ptr      <= base_ptr;
            // Handshake PIDs carry no payload; level here excludes a same-cycle write.
            end_ptr     <= (send_pid[1:0] == 2'b11) ? base_ptr + pkt_len : base_ptr;
            pkt_start_q <= 1'b1;
            state       <= S_START;
          end
        end
        S_START: state <= S_SEND;
        S_SEND: begin
          if (tx.tx_data_get && tx.tx_data_avail) rd_ptr <= rd_ptr + PTR_W'(1);
          if (tx.pkt_end) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
`ifdef USB_TX_RETRY_EN
          state <= S_WAIT_ACK;
`else
          base_ptr <= rd_ptr;
          state    <= S_IDLE;
`endif
        end
`ifdef USB_TX_RETRY_EN
        S_WAIT_ACK: begin
          if (ack) begin
            base_ptr <= rd_ptr;
            state    <= S_IDLE;
          end else if (retry) begin
            rd_ptr      <= base_ptr;
            pkt_start_q <= 1'b1;
            state       <= S_START;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_fs_tx_buffer.sv
// Self-checking bench for usb_fs_tx_buffer: random payloads checked against a byte-queue model.
// Covers both builds; the retry sequence runs only when USB_TX_RETRY_EN is defined.
module tb_usb_fs_tx_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, send_req, ack, retry;
  logic [7:0] wr_data;
  logic [3:0] send_pid;
  logic       wr_full, busy, done;
  logic [7:0] level;
  logic [2:0] state_dbg;

  usb_fs_tx_buffer_if txif ();

  usb_fs_tx_buffer #(.ADDR_W(7), .MAX_PKT(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_full   (wr_full),
    .level     (level),
    .send_req  (send_req),
    .send_pid  (send_pid),
    .busy      (busy),
    .done      (done),
    .ack       (ack),
    .retry     (retry),
    .tx        (txif),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Bytes held in the buffer, oldest first; front entries form the next packet.
  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
    if (exp_q.size() < 128) exp_q.push_back(b);
  endtask

  task automatic write_rand(input int cnt);
    for (int i = 0; i < cnt; i++) write_byte(8'($urandom_range(0, 255)));
  endtask

  task automatic start_packet(input logic [3:0] p, input bit same_wr, input logic [7:0] wb,
                              output int n);
    int sz;
    sz = exp_q.size();
    n = (p[1:0] == 2'b11) ? ((sz < 64) ? sz : 64) : 0;
    send_req = 1'b1;
    send_pid = p;
    if (same_wr) begin
      wr_en = 1'b1;
      wr_data = wb;
    end
    tick();
    send_req = 1'b0;
    wr_en = 1'b0;
    if (same_wr && exp_q.size() < 128) exp_q.push_back(wb);
    chk("pkt_start_on", txif.pkt_start, 1);
    chk("busy_start", busy, 1);
    chk("pid", txif.pid, p);
    chk("avail_in_start", txif.tx_data_avail, 0);
    tick();
    chk("pkt_start_off", txif.pkt_start, 0);
  endtask

  task automatic serve(input int n);
    int served = 0;
    int guard = 0;
    while (served < n && guard < 400) begin
      guard++;
      chk("avail", txif.tx_data_avail, 1);
      chk("tx_data", txif.tx_data, exp_q[served]);
      if ($urandom_range(0, 3) == 0) begin
        tick();
      end else begin
        txif.tx_data_get = 1'b1;
        tick();
        txif.tx_data_get = 1'b0;
        served++;
      end
    end
    chk("served", served, n);
    chk("avail_end", txif.tx_data_avail, 0);
    txif.tx_data_get = 1'b1;
    tick();
    txif.tx_data_get = 1'b0;
    chk("avail_after_spurious_get", txif.tx_data_avail, 0);
  endtask

  task automatic end_packet();
    txif.pkt_end = 1'b1;
    tick();
    txif.pkt_end = 1'b0;
    chk("done_on", done, 1);
    chk("busy_done", busy, 1);
    tick();
    chk("done_off", done, 0);
  endtask

  task automatic release_packet(input int n);
`ifdef USB_TX_RETRY_EN
    chk("busy_wait_ack", busy, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
`endif
    for (int i = 0; i < n; i++) void'(exp_q.pop_front());
    chk("busy_idle", busy, 0);
    chk("level_after", level, exp_q.size());
    chk("wr_full_after", wr_full, (exp_q.size() == 128) ? 1 : 0);
  endtask

  task automatic send_packet(input logic [3:0] p);
    int n;
    start_packet(p, 1'b0, 8'h00, n);
    serve(n);
    end_packet();
    release_packet(n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    wr_en = 1'b0; wr_data = 8'h00; send_req = 1'b0; send_pid = 4'h0;
    ack = 1'b0; retry = 1'b0;
    txif.tx_data_get = 1'b0; txif.pkt_end = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pkt_start", txif.pkt_start, 0);
    chk("rst_avail", txif.tx_data_avail, 0);
    chk("rst_wr_full", wr_full, 0);
    chk("rst_pid", txif.pid, 0);
    chk("rst_level", level, 0);

    // Three-byte DATA0 packet.
    write_byte(8'h11);
    chk("level_1", level, 1);
    write_byte(8'h22);
    write_byte(8'h33);
    chk("level_3", level, 3);
    send_packet(4'b0011);

    // 100 bytes: first packet capped at 64, second takes the remaining 36.
    write_rand(100);
    chk("level_100", level, 100);
    send_packet(4'b0011);
    chk("level_36", level, 36);
    send_packet(4'b1011);

    // Handshake PID serves nothing; a write alongside send_req joins the next packet.
    write_rand(5);
    send_packet(4'b0010);
    chk("level_hs", level, 5);
    start_packet(4'b0011, 1'b1, 8'($urandom_range(0, 255)), n);
    chk("n_excl_same_cycle", n, 5);
    serve(n);
    end_packet();
    release_packet(n);
    chk("level_leftover", level, 1);
    send_packet(4'b1011);

    // Fill to capacity, ignored overflow write, then drain across the pointer wrap.
    write_rand(128);
    chk("full_set", wr_full, 1);
    chk("level_full", level, 128);
    write_byte(8'hEE);
    chk("level_overflow", level, 128);
    send_packet(4'b0011);
    chk("level_64", level, 64);
    write_rand(64);
    send_packet(4'b1011);
    send_packet(4'b0011);
    chk("level_drained", level, 0);

`ifdef USB_TX_RETRY_EN
    // Replay: same PID and bytes, then ack together with retry releases.
    write_byte(8'hA5);
    write_byte(8'h5A);
    start_packet(4'b1011, 1'b0, 8'h00, n);
    serve(n);
    end_packet();
    chk("busy_before_retry", busy, 1);
    retry = 1'b1;
    tick();
    retry = 1'b0;
    chk("retry_pkt_start", txif.pkt_start, 1);
    chk("retry_pid", txif.pid, 4'b1011);
    chk("retry_level_kept", level, 2);
    tick();
    serve(n);
    end_packet();
    ack = 1'b1;
    retry = 1'b1;
    tick();
    ack = 1'b0;
    retry = 1'b0;
    for (int i = 0; i < n; i++) void'(exp_q.pop_front());
    chk("ack_wins_busy", busy, 0);
    chk("ack_wins_pkt_start", txif.pkt_start, 0);
    chk("ack_level", level, 0);
`else
    // ack/retry have no effect without the retry build.
    write_byte(8'hA5);
    write_byte(8'h5A);
    start_packet(4'b1011, 1'b0, 8'h00, n);
    serve(n);
    retry = 1'b1;
    end_packet();
    retry = 1'b0;
    release_packet(n);
    chk("no_ack_pkt_start", txif.pkt_start, 0);
`endif

    // Reset mid-packet aborts with no done, then a one-byte packet works.
    write_rand(3);
    start_packet(4'b0011, 1'b0, 8'h00, n);
    chk("abort_tx_data", txif.tx_data, exp_q[0]);
    txif.tx_data_get = 1'b1;
    tick();
    txif.tx_data_get = 1'b0;
    reset = 1'b0;
    tick();
    exp_q.delete();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pkt_start", txif.pkt_start, 0);
    chk("abort_avail", txif.tx_data_avail, 0);
    chk("abort_level", level, 0);
    chk("abort_pid", txif.pid, 0);
    chk("abort_wr_full", wr_full, 0);
    reset = 1'b1;
    tick();
    chk("abort_no_done", done, 0);
    write_rand(1);
    send_packet(4'b0011);
    chk("final_level", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_fs_tx_buffer.md
# usb_fs_tx_buffer

Packet-level transmit buffer sitting directly upstream of the USB full-speed transmitter, in the `clk` domain. Application logic writes payload bytes into an internal FIFO and commits a packet with a PID. The block then:
- issues `pkt_start`/`pid` to the transmitter,
- serves bytes through the `tx_data_avail`/`tx_data_get`/`tx_data` pull interface,
- reports completion on `pkt_end`.

Optionally it retains sent data so an unacknowledged IN packet can be replayed.

## Interface
Parameters:
- `ADDR_W`, 7: FIFO depth = 2^ADDR_W bytes (128).
- `MAX_PKT`, 64: maximum payload bytes served per packet; must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe; accepted when `wr_full`=0.
- `wr_data`  in  8  payload byte.
- `wr_full`  out  1  FIFO holds 2^ADDR_W bytes.
- `level`  out  ADDR_W+1  bytes stored, counted from the release pointer.
- `send_req`  in  1  commit packet; accepted only in IDLE.
- `send_pid`  in  4  PID for the committed packet.
- `busy`  out  1  not in IDLE.
- `done`  out  1  one-cycle pulse when a packet's transmission ends.
- `ack`  in  1  host acknowledged the last packet (used only with `USB_TX_RETRY_EN`).
- `retry`  in  1  replay the last packet (used only with `USB_TX_RETRY_EN`).
- `pkt_start`  out  1  one-cycle pulse to the transmitter.
- `pid`  out  4  registered PID; stable while `busy`.
- `tx_data_avail`  out  1  bytes of the current packet remain.
- `tx_data_get`  in  1  one-cycle pop strobe from the transmitter.
- `tx_data`  out  8  show-ahead byte at the read pointer.
- `pkt_end`  in  1  one-cycle pulse from the transmitter when EOP completes.

## Operation
Pointers:
- `wr_ptr`, `rd_ptr`, `base_ptr`, `end_ptr` are each ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1).
- `level` = `wr_ptr` − `base_ptr`.
- `wr_full` = (`level` == 2^ADDR_W).

Writes:
- Accepted in any state when not full: `mem[wr_ptr]` ← `wr_data`, `wr_ptr`++.
- `wr_en` while full is ignored, with no side effect.

States:
- IDLE → START on `send_req`.
  - Latch `pid` ← `send_pid`.
  - If `send_pid[1:0]`==2'b11 (data PID): `end_ptr` ← `base_ptr` + min(`level`, `MAX_PKT`). `level` is the value before any same-cycle write, so a byte written in the same cycle belongs to the next packet.
  - Otherwise (handshake PID): `end_ptr` ← `base_ptr`, so no bytes are served.
- START: assert `pkt_start` for exactly this one cycle, then → SEND.
- SEND:
  - `tx_data_avail` = (`rd_ptr` != `end_ptr`).
  - `tx_data` = `mem[rd_ptr[ADDR_W-1:0]]`.
  - `tx_data_get` while avail: `rd_ptr`++. `tx_data_get` while not avail is ignored.
  - `pkt_end` → DONE.
- DONE: assert `done` for one cycle.
  - Without the macro: `base_ptr` ← `rd_ptr`, then → IDLE.
  - With the macro: → WAIT_ACK.
- WAIT_ACK (macro only):
  - `ack`: `base_ptr` ← `rd_ptr`, → IDLE.
  - `retry`: `rd_ptr` ← `base_ptr`, → START, re-issuing the same `pid` and `end_ptr`.
  - `ack` and `retry` in the same cycle: `ack` wins.

Other rules:
- `tx_data_avail` = 0 outside SEND.
- `send_req` outside IDLE is ignored.
- `pkt_end` outside SEND is ignored.
- Asserting `reset` mid-packet aborts immediately. All pointers go to 0, state goes to IDLE, and FIFO contents are discarded; no `done` is produced.

## Timing
- Reset values:
  - `busy`, `done`, `pkt_start`, `tx_data_avail`, `wr_full` = 0.
  - `pid`, `level` = 0.
  - `tx_data` is don't-care.
- `send_req` at cycle N → `busy`=1 and `pkt_start`=1 at N+1; `tx_data_avail` valid from N+2.
- `tx_data_get` at M → `rd_ptr`, `tx_data`, and `tx_data_avail` update at M+1. The transmitter samples no earlier than one byte time later, so no prefetch stage is needed.
- `pkt_end` at K → `done`=1 at K+1.
  - Without the macro: `busy`=0 and `level` reduced at K+2.
  - With the macro: `busy` stays 1 until the cycle after `ack`.
- `level` reflects a write one cycle after `wr_en`.

## Configuration
- `USB_TX_RETRY_EN` defined:
  - WAIT_ACK exists.
  - Sent bytes are kept until `ack`.
  - `retry` replays the packet with identical data and PID.
- Not defined:
  - No WAIT_ACK; DONE releases bytes and returns to IDLE.
  - `ack` and `retry` are ignored.

## Test plan
- Write 0x11,0x22,0x33; `send_req` with PID 4'b0011 → `pkt_start` one cycle; `tx_data` 0x11→0x22→0x33 across three `tx_data_get`; `tx_data_avail`=0 after the third; `pkt_end` → `done` pulse; `level`=0.
- 100 bytes buffered, DATA0 sent → exactly 64 bytes served; after `done`, `level`=36 and the next packet starts with byte 64.
- ACK PID 4'b0010 with 5 bytes buffered → `pkt_start`, `tx_data_avail` never 1, `done` on `pkt_end`; `level` stays 5.
- Write 128 bytes → `wr_full`=1; a 129th write is ignored (`level`=128). After a 64-byte send, `level`=64; wrap across the pointer boundary preserves byte order.
- Retry (macro on): send 0xA5,0x5A, `pkt_end`, `retry` → second `pkt_start` with the same PID and 0xA5,0x5A again; `ack` → `busy`=0, `level`=0. Macro off: `done` then `busy`=0 with no `ack` needed.
- Assert `reset` after the first `tx_data_get` → all outputs return to reset values next cycle; no `done`; a new 1-byte packet then sends correctly.
